// File: rtl/match_write_arbiter_if.sv
// Match-memory write port: arbiter drives the write strobe, address and record,
// memory answers with ready.
interface match_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W+1:0] mem_wdata;
  logic              mem_ready;

  modport master (output mem_wr_en, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_wr_en, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/match_write_arbiter.sv
// Four-way round-robin arbiter that logs comparator matches into a linear
// match memory, with fill count, full flag, sticky overflow and log clear.
module match_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            grant,
  match_write_arbiter_if.master mem,
  input  logic                  clear,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_d;
  logic              ovf_d, full_d;
  logic [1:0]        last_q, last_d;
  logic              pend_q, pend_d;
  logic [3:0]        grant_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [DATA_W+1:0] wdata_d;

  logic [DATA_W-1:0] data_arr [4];
  logic [1:0]        pick, cand;
  logic              found;

  always_comb begin
    for (int i = 0; i < 4; i++) data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count;
    ovf_d   = overflow;
    last_d  = last_q;
    pend_d  = pend_q;
    grant_d = '0;
    wr_en_d = mem.mem_wr_en;
    maddr_d = mem.mem_addr;
    wdata_d = mem.mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (found) begin
          state_d = WRITE;
          grant_d = 4'(1) << pick;
          wr_en_d = 1'b1;
          maddr_d = addr_q;
          wdata_d = {pick, data_arr[pick]};
          last_d  = pick;
        end
      end
      WRITE: begin
        pend_d = pend_q | clear;
        if (mem.mem_ready) begin
          wr_en_d = 1'b0;
          state_d = IDLE;
          // A clear seen during the write wins over the increment and FULL.
          if (pend_q || clear) begin
            addr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count + CNT_W'(1);
            if (count + CNT_W'(1) == DEPTH) state_d = FULL;
          end
        end
      end
      FULL: begin
        if (clear) begin
          state_d = IDLE;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (|req) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = (count_d == DEPTH);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      count         <= '0;
      full          <= 1'b0;
      overflow      <= 1'b0;
      last_q        <= 2'd3;
      pend_q        <= 1'b0;
      grant         <= '0;
      mem.mem_wr_en <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count         <= count_d;
      full          <= full_d;
      overflow      <= ovf_d;
      last_q        <= last_d;
      pend_q        <= pend_d;
      grant         <= grant_d;
      mem.mem_wr_en <= wr_en_d;
      mem.mem_addr  <= maddr_d;
      mem.mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_match_write_arbiter.sv
// Bench for match_write_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_match_write_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      grant;
  logic            clear;
  logic [AW:0]     count;
  logic            full;
  logic            overflow;

  match_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

  match_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .grant(grant),
    .mem(mem_bus), .clear(clear), .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a write in flight or not, a fill pointer and a record count.
  bit          m_writing, m_wr_en, m_ovf, m_pend;
  logic [3:0]  m_grant;
  int          m_count, m_wptr, m_last, m_addr;
  logic [DW+1:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_writing = 1'b0; m_wr_en = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
    m_grant = '0; m_count = 0; m_wptr = 0; m_last = 3; m_addr = 0; m_wdata = '0;
  endtask

  task automatic model_step();
    int  pick;
    bit  found;
    if (m_writing) begin
      m_grant = '0;
      if (clear) m_pend = 1'b1;
      if (mem_bus.mem_ready) begin
        m_writing = 1'b0;
        m_wr_en   = 1'b0;
        if (m_pend) begin
          m_wptr = 0; m_count = 0; m_ovf = 1'b0; m_pend = 1'b0;
        end else begin
          m_wptr  = (m_wptr + 1) % DEPTH;
          m_count = m_count + 1;
        end
      end
    end else if (clear) begin
      m_wptr = 0; m_count = 0; m_ovf = 1'b0;
    end else if (m_count == DEPTH) begin
      if (req != 0) m_ovf = 1'b1;
    end else begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last + k) % 4;
        if (!found && req[i]) begin found = 1'b1; pick = i; end
      end
      if (found) begin
        m_writing = 1'b1;
        m_wr_en   = 1'b1;
        m_grant   = 4'(1 << pick);
        m_addr    = m_wptr;
        m_wdata   = {2'(pick), req_data[pick*DW +: DW]};
        m_last    = pick;
      end
    end
  endtask

  task automatic compare_all();
    check("grant", 64'(grant), 64'(m_grant));
    check("wr_en", 64'(mem_bus.mem_wr_en), 64'(m_wr_en));
    check("count", 64'(count), 64'(m_count));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (m_wr_en) begin
      check("addr", 64'(mem_bus.mem_addr), 64'(m_addr));
      check("wdata", 64'(mem_bus.mem_wdata), 64'(m_wdata));
    end
  endtask

  // Inputs are set at the falling edge; model and DUT both see them at the next rise.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [3:0] gq[$];
  int         aq[$];
  int         cq[$];
  logic [3:0] exp_g [5];
  int         wr_cnt, g_cnt;

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_rst = 1'b0; req = '0; req_data = '0; clear = 1'b0; mem_bus.mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_addr", 64'(mem_bus.mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_bus.mem_wdata), 64'd0);
    n_rst = 1'b1;

    // All four requesting, memory always ready: strict rotation.
    req = 4'hF; req_data = {8'h13, 8'h12, 8'h11, 8'h10}; mem_bus.mem_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (grant != 0) begin
        gq.push_back(grant);
        aq.push_back(int'(mem_bus.mem_addr));
        cq.push_back(int'(mem_bus.mem_wdata[DW+1:DW]));
      end
    end
    check("rr_ngrants", 64'(gq.size()), 64'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < gq.size()) begin
        check("rr_grant", 64'(gq[j]), 64'(exp_g[j]));
        check("rr_addr", 64'(aq[j]), 64'(j));
        check("rr_chan", 64'(cq[j]), 64'(j % 4));
      end
    end
    req = '0;
    clear = 1'b1; cyc(); clear = 1'b0;
    check("clr_count", 64'(count), 64'd0);

    // Memory stalls three cycles: one grant pulse, four strobe cycles.
    req = 4'b0100; mem_bus.mem_ready = 1'b0; wr_cnt = 0; g_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_bus.mem_ready = 1'b1;
      cyc();
      if (k == 0) req = '0;
      wr_cnt += int'(mem_bus.mem_wr_en);
      g_cnt  += int'(grant != 0);
    end
    check("stall_wr_cycles", 64'(wr_cnt), 64'd4);
    check("stall_grants", 64'(g_cnt), 64'd1);
    check("stall_count", 64'(count), 64'd1);

    // Fill the log, then provoke overflow, then clear.
    clear = 1'b1; cyc(); clear = 1'b0;
    req = 4'b0001; mem_bus.mem_ready = 1'b1;
    repeat (2 * DEPTH) cyc();
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'(DEPTH));
    repeat (3) cyc();
    check("full_nogrant", 64'(grant), 64'd0);
    check("full_ovf", 64'(overflow), 64'd1);
    req = '0; clear = 1'b1; cyc(); clear = 1'b0;
    check("clr_full", 64'(full), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);

    // Clear during a stalled write: write lands, increment is discarded.
    req = 4'b0010; mem_bus.mem_ready = 1'b0;
    cyc();
    clear = 1'b1; req = '0;
    cyc();
    clear = 1'b0; mem_bus.mem_ready = 1'b1;
    cyc();
    check("pend_count", 64'(count), 64'd0);
    req = 4'b0100; mem_bus.mem_ready = 1'b0;
    cyc();
    check("pend_addr", 64'(mem_bus.mem_addr), 64'd0);
    req = '0;

    // Reset in the middle of a write.
    n_rst = 1'b0;
    #1;
    check("rst_wr_en", 64'(mem_bus.mem_wr_en), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    compare_all();
    req = 4'hF; mem_bus.mem_ready = 1'b1;
    cyc();
    check("rst_next_grant", 64'(grant), 64'd1);
    req = '0;
    cyc();

    // Random traffic: requesters hold until granted, random stalls and clears.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_grant[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      mem_bus.mem_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/match_write_arbiter.md
MATCH_WRITE_ARBITER -- requirements
Module: match_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each requester's match payload.
REQ-002 SHALL have parameter ADDR_W, default 8: match-memory address width; memory depth is 2^ADDR_W records.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req, input, 4 bits: per-comparator match request (bit i = comparator i).
REQ-006 SHALL have port req_data, input, 4*DATA_W bits: payload i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port grant, output, 4 bits: one-hot acknowledge pulse to the selected requester.
REQ-008 SHALL have port mem_wr_en, output, 1 bit: write strobe to match memory.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: write address.
REQ-010 SHALL have port mem_wdata, output, DATA_W+2 bits: record {chan_id[1:0], payload}.
REQ-011 SHALL have port mem_ready, input, 1 bit: memory accepts the write this cycle.
REQ-012 SHALL have port clear, input, 1 bit: synchronous log clear request.
REQ-013 SHALL have port count, output, ADDR_W+1 bits: records stored since the last clear.
REQ-014 SHALL have port full, output, 1 bit: count == 2^ADDR_W.
REQ-015 SHALL have port overflow, output, 1 bit: sticky; a request arrived while full.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE and FULL; all outputs SHALL be registered.
REQ-017 IDLE with any req bit set and not full SHALL select one requester round-robin, latch its index and payload, and go to WRITE on the same edge.
REQ-018 Round-robin search SHALL start at (last_granted+1) mod 4 and wrap; last_granted SHALL update only on selection.
REQ-019 grant[sel] SHALL be high for exactly the first cycle of WRITE; grant SHALL be 0 at all other times.
REQ-020 Requesters SHALL hold req and req_data until grant and drop req the following cycle; the arbiter SHALL NOT re-sample data after latching it.
REQ-021 In WRITE: mem_wr_en=1, mem_addr=addr register, mem_wdata={sel, latched payload}, all held stable while mem_ready=0.
REQ-022 In WRITE with mem_ready=1 (the commit): addr SHALL increment mod 2^ADDR_W, count SHALL increment, and next state SHALL be FULL if the new count equals 2^ADDR_W, else IDLE.
REQ-023 Latency: a req seen in IDLE at cycle N SHALL yield grant and mem_wr_en at N+1; with mem_ready=1, IDLE at N+2; peak throughput is one record per 2 cycles.
REQ-024 In FULL, no grant SHALL be issued; any req bit high in a cycle SHALL set overflow, which holds until clear or reset.
REQ-025 clear in IDLE or FULL SHALL zero addr, count and overflow and enter IDLE next cycle; no selection occurs in that cycle.
REQ-026 clear during WRITE SHALL be latched as pending; the write SHALL complete, and on commit the clear SHALL apply (addr=0, count=0, overflow=0, state IDLE), overriding the increment and the FULL transition.
REQ-027 full SHALL equal (count == 2^ADDR_W) each cycle; addr SHALL read 0 when full.

Reset
REQ-028 On n_rst low, asynchronously: state=IDLE, grant=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, count=0, full=0, overflow=0, last_granted=3, clear-pending=0.
REQ-029 Reset asserted mid-WRITE SHALL abort the write with mem_wr_en low immediately; no commit SHALL occur.

Verification
REQ-030 Post-reset, req=4'b1111 held, mem_ready=1 -> grants in order 0001,0010,0100,1000,0001 on every second cycle; mem_addr 0,1,2,3,4; chan_id 0,1,2,3,0.
REQ-031 req=4'b0100, mem_ready=0 for 3 cycles then 1 -> grant=0100 for one cycle only; mem_wr_en high for 4 cycles with addr and data stable; count 0->1.
REQ-032 ADDR_W=2, 4 commits -> full=1, count=4, addr=0; then req=0001 -> no grant, overflow=1; clear -> count=0, full=0, overflow=0, IDLE.
REQ-033 clear asserted in the first WRITE cycle with mem_ready=0, then mem_ready=1 -> write commits to addr 0; after the commit count=0, addr=0 (the increment is overridden).
REQ-034 n_rst pulsed low during WRITE -> mem_wr_en and grant drop asynchronously, count unchanged at 0, next grant goes to requester 0.
